// File: rtl/rotor_table_loader_if.sv
// rtl/rotor_table_loader_if.sv - host entry stream handshake bundle for the rotor table loader
interface rotor_table_loader_if #(
  parameter int CODE_W = 6
);
  logic              in_valid;
  logic [CODE_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/rotor_table_loader.sv
// rtl/rotor_table_loader.sv - replays host table entries as rotor/reflector load sequence (option: ROTOR_LOADER_PERM_CHECK_EN)
module rotor_table_loader #(
  parameter int TBL_DEPTH = 64,
  parameter int CODE_W    = 6,
  parameter int NUM_TBL   = 3
) (
  input  logic                  clk,
  input  logic                  srst_n,
  rotor_table_loader_if.slave   in_if,
  input  logic                  start,
  output logic                  load,
  output logic [1:0]            table_idx,
  output logic [CODE_W-1:0]     code_out,
  output logic                  busy,
  output logic                  done,
  output logic                  perm_err,
  output logic [1:0]            err_tbl
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CODE_W-1:0] ent_q;
  logic [1:0]        tbl_q;
  logic              load_q;
  logic [1:0]        table_idx_q;
  logic [CODE_W-1:0] code_q;
  logic              busy_q;
  logic              done_q;

  logic beat;
  logic ent_last;
  logic tbl_last;

  // Handshake decode: ready depends on state only, so the host sees no comb path from its own valid.
  always_comb begin
    in_if.in_ready = (state_q == S_LOAD);
    beat           = in_if.in_valid & (state_q == S_LOAD);
    ent_last       = (ent_q == CODE_W'(TBL_DEPTH - 1));
    tbl_last       = (tbl_q == 2'(NUM_TBL - 1));
  end

  // Session FSM with counters and registered load/code/index outputs.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= S_IDLE;
      ent_q       <= '0;
      tbl_q       <= '0;
      load_q      <= 1'b0;
      table_idx_q <= '0;
      code_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      load_q <= beat;
      done_q <= 1'b0;
      if (beat) begin
        code_q      <= in_if.in_data;
        table_idx_q <= tbl_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            ent_q   <= '0;
            tbl_q   <= '0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            // Counter width equals log2(TBL_DEPTH), so the increment wraps to 0 on its own.
            ent_q <= ent_q + 1'b1;
            if (ent_last) begin
              if (tbl_last) begin
                state_q <= S_FLUSH;
                tbl_q   <= '0;
              end else begin
                tbl_q <= tbl_q + 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load      = load_q;
  assign table_idx = table_idx_q;
  assign code_out  = code_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef ROTOR_LOADER_PERM_CHECK_EN
  logic [TBL_DEPTH-1:0] seen_q;
  logic                 perm_err_q;
  logic [1:0]           err_tbl_q;

  // Per-table seen mask; a repeated value flags the table, but the entry is still forwarded.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      seen_q     <= '0;
      perm_err_q <= 1'b0;
      err_tbl_q  <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      seen_q     <= '0;
      perm_err_q <= 1'b0;
    end else if (beat) begin
      if (seen_q[in_if.in_data] && !perm_err_q) begin
        perm_err_q <= 1'b1;
        err_tbl_q  <= tbl_q;
      end
      if (ent_last) begin
        seen_q <= '0;
      end else begin
        seen_q <= seen_q | (TBL_DEPTH'(1) << in_if.in_data);
      end
    end
  end

  assign perm_err = perm_err_q;
  assign err_tbl  = err_tbl_q;
`else
  assign perm_err = 1'b0;
  assign err_tbl  = 2'b00;
`endif

endmodule

// File: tb/tb_rotor_table_loader.sv
// tb/tb_rotor_table_loader.sv - self-checking bench for rotor_table_loader
module tb_rotor_table_loader;

  localparam int CODE_W    = 6;
  localparam int TBL_DEPTH = 64;
  localparam int NUM_TBL   = 3;
  localparam int TOTAL     = TBL_DEPTH * NUM_TBL;

  logic              clk = 1'b0;
  logic              srst_n = 1'b0;
  logic              start = 1'b0;
  logic              load;
  logic [1:0]        table_idx;
  logic [CODE_W-1:0] code_out;
  logic              busy;
  logic              done;
  logic              perm_err;
  logic [1:0]        err_tbl;

  rotor_table_loader_if #(.CODE_W(CODE_W)) bus ();

  rotor_table_loader #(
    .TBL_DEPTH (TBL_DEPTH),
    .CODE_W    (CODE_W),
    .NUM_TBL   (NUM_TBL)
  ) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .in_if     (bus.slave),
    .start     (start),
    .load      (load),
    .table_idx (table_idx),
    .code_out  (code_out),
    .busy      (busy),
    .done      (done),
    .perm_err  (perm_err),
    .err_tbl   (err_tbl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        tbl;
    logic [CODE_W-1:0] code;
  } exp_t;

  typedef struct {
    logic              start;
    logic              valid;
    logic [CODE_W-1:0] data;
    logic              exp_ready;
    logic              exp_load;
    logic              exp_busy;
    logic              exp_done;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t mon_e;
  logic have_last = 1'b0;
  logic mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_load = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CODE_W-1:0] vdata(input int i, input bit dup);
    int e;
    e = i % TBL_DEPTH;
    if (dup && (i / TBL_DEPTH) == 1 && (e == 2 || e == 5)) return 6'h07;
    return CODE_W'(e);
  endfunction

  // Scoreboard consumer: every load pops one expected entry; between loads outputs must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (load === 1'b1) begin
        n_load++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_load: got load=1 tbl=%0d code=0x%0h, expected no load", table_idx, code_out);
        end else begin
          mon_e = sb.pop_front();
          chk("load_tbl", 32'(table_idx), 32'(mon_e.tbl));
          chk("load_code", 32'(code_out), 32'(mon_e.code));
          last_exp  = mon_e;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        chk("hold_code", 32'(code_out), 32'(last_exp.code));
        chk("hold_tbl", 32'(table_idx), 32'(last_exp.tbl));
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_tbl"}, 32'(table_idx), 0);
    chk({tag, "_code"}, 32'(code_out), 0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_perm"}, 32'(perm_err), 0);
    chk({tag, "_errtbl"}, 32'(err_tbl), 0);
  endtask

  // Asynchronous reset mid-cycle, checked before the next clock edge, then released.
  task automatic async_reset(input string tag);
    bus.in_valid = 1'b0;
    start        = 1'b0;
    mon_en       = 1'b0;
    #2;
    srst_n = 1'b0;
    #1;
    reset_checks(tag);
    sb.delete();
    have_last = 1'b0;
    tick();
    tick();
    srst_n = 1'b0;
    #0;
    srst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk({tag, "_post_ready"}, 32'(bus.in_ready), 0);
      chk({tag, "_post_busy"}, 32'(busy), 0);
    end
    mon_en = 1'b1;
  endtask

  task automatic run_session(input bit gap, input bit midstart, input bit dup, input int abort_at);
    int   i;
    int   k;
    int   load0;
    logic exp_perr;
    i = 0;
    k = 0;
    exp_perr = 1'b0;
    load0 = n_load;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(bus.in_ready), 1);
    chk("start_perm_clear", 32'(perm_err), 0);
    while (i < TOTAL) begin
      if (abort_at >= 0 && i == abort_at) begin
        async_reset("abort");
        return;
      end
      start = 1'b0;
      if (gap && (k % 3) == 2) begin
        bus.in_valid = 1'b0;
      end else begin
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = vdata(i, dup);
        e.tbl  = 2'(i / TBL_DEPTH);
        e.code = vdata(i, dup);
        sb.push_back(e);
        i++;
        start = midstart && (i == 31);
      end
      #1;
      chk("load_ready", 32'(bus.in_ready), 1);
      tick();
      start = 1'b0;
      k++;
`ifdef ROTOR_LOADER_PERM_CHECK_EN
      exp_perr = dup && (i >= TBL_DEPTH + 6);
`endif
      chk("perm_err", 32'(perm_err), 32'(exp_perr));
      if (exp_perr) chk("err_tbl", 32'(err_tbl), 1);
    end
    // Offer more data in FLUSH/DONE; it must not be accepted.
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h2a;
    chk("flush_ready", 32'(bus.in_ready), 0);
    chk("flush_busy", 32'(busy), 1);
    chk("flush_done", 32'(done), 0);
    tick();
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_ready", 32'(bus.in_ready), 0);
    chk("done_perm", 32'(perm_err), 32'(exp_perr));
    tick();
    bus.in_valid = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_ready", 32'(bus.in_ready), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("load_count", 32'(n_load - load0), 32'(TOTAL));
    tick();
    tick();
    chk("final_perm", 32'(perm_err), 32'(exp_perr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tv[13];
    for (int r = 0; r < 10; r++) tv[r] = '{1'b0, 1'b1, CODE_W'(r + 3), 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b1, 6'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 6'h12, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b0, 6'h13, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    reset_checks("reset");
    srst_n = 1'b1;
    tick();
    reset_checks("released");
    mon_en = 1'b1;

    for (int r = 0; r < 13; r++) begin
      start        = tv[r].start;
      bus.in_valid = tv[r].valid;
      bus.in_data  = tv[r].data;
      #1;
      chk($sformatf("vec%0d_ready", r), 32'(bus.in_ready), 32'(tv[r].exp_ready));
      tick();
      start = 1'b0;
      chk($sformatf("vec%0d_load", r), 32'(load), 32'(tv[r].exp_load));
      chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tv[r].exp_busy));
      chk($sformatf("vec%0d_done", r), 32'(done), 32'(tv[r].exp_done));
    end
    async_reset("vecrst");

    run_session(1'b0, 1'b0, 1'b0, -1);
    run_session(1'b1, 1'b0, 1'b0, -1);
    run_session(1'b0, 1'b1, 1'b0, -1);
    run_session(1'b0, 1'b0, 1'b1, -1);
    run_session(1'b1, 1'b0, 1'b0, -1);
    run_session(1'b0, 1'b0, 1'b0, 100);
    run_session(1'b0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
